// File: rtl/seq_gen_serial_if.sv
// Request/status bundle between a pattern-transmit client and seq_gen_serial.
// The client drives the request side; the transmitter drives the serial stream and status.
interface seq_gen_serial_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             use_default;
    logic [WIDTH-1:0] pat_in;
    logic [CNT_W-1:0] rep;
    logic             abort;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             done;

    modport master (
        output start, use_default, pat_in, rep, abort,
        input  ready, out, out_valid, done
    );

    modport slave (
        input  start, use_default, pat_in, rep, abort,
        output ready, out, out_valid, done
    );
endinterface

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// rep back-to-back copies, then pulses done for one cycle.
module seq_gen_serial #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = 4'b1011,
    parameter int               CNT_W       = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    seq_gen_serial_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_pat_next;
    logic [IDX_W-1:0] w_idx_next;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pat   <= w_pat_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pat_next   = r_pat;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                // abort wins over a simultaneous start; a zero repeat count is a no-op
                if (bus.start && !bus.abort && (bus.rep != '0)) begin
                    w_pat_next   = bus.use_default ? DEFAULT_PAT : bus.pat_in;
                    w_idx_next   = IDX_TOP;
                    w_cnt_next   = bus.rep;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    w_state_next = IDLE;
                end else if (r_idx == '0) begin
                    w_idx_next = IDX_TOP;
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = DONE;
                    end
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs depend only on registers, so reset clears them without waiting for a clock.
    assign bus.ready     = (r_state == IDLE);
    assign bus.out_valid = (r_state == SHIFT);
    assign bus.out       = (r_state == SHIFT) ? r_pat[r_idx] : 1'b0;
    assign bus.done      = (r_state == DONE);
endmodule

// File: tb/tb_seq_gen_serial.sv
// Directed bench for seq_gen_serial: hand-computed serial streams, done/ready timing,
// abort, zero-repeat and asynchronous reset cases.
module tb_seq_gen_serial;
    logic clk;
    logic rst;

    seq_gen_serial_if #(.WIDTH(4), .CNT_W(4)) bus ();

    seq_gen_serial #(.WIDTH(4), .DEFAULT_PAT(4'b1011), .CNT_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] g_mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ready"}, 64'(bus.ready), 64'd1);
        chk({tag, ".vld"},   64'(bus.out_valid), 64'd0);
        chk({tag, ".out"},   64'(bus.out), 64'd0);
        chk({tag, ".done"},  64'(bus.done), 64'd0);
    endtask

    // Issue one start and check every following cycle; abort_at<0 means run to completion.
    task automatic send(input string tag, input logic ud, input logic [3:0] pat,
                        input logic [3:0] r, input int nbits, input logic [63:0] exp_bits,
                        input int abort_at, input bit poke);
        logic [3:0] sh;
        int         sent;
        sh     = '0;
        sent   = 0;
        g_mask = '0;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.use_default = ud;
        bus.pat_in      = pat;
        bus.rep         = r;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.use_default = ~ud;
        bus.pat_in      = ~pat;
        bus.rep         = 4'd0;
        for (int i = 0; i < nbits; i++) begin
            chk($sformatf("%s.vld%0d", tag, i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("%s.bit%0d", tag, i), 64'(bus.out), 64'(exp_bits[nbits-1-i]));
            chk($sformatf("%s.rdy%0d", tag, i), 64'(bus.ready), 64'd0);
            chk($sformatf("%s.dn%0d", tag, i),  64'(bus.done), 64'd0);
            sh = {sh[2:0], bus.out};
            if (i >= 3 && sh == 4'b1011) g_mask[i] = 1'b1;
            sent++;
            if (poke) begin
                bus.start       = 1'b1;
                bus.rep         = 4'd1;
                bus.use_default = 1'b1;
            end
            if (i == abort_at) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (abort_at >= 0) begin
            check_idle({tag, ".abt"});
            @(negedge clk);
            check_idle({tag, ".abt2"});
        end else begin
            chk({tag, ".done"},  64'(bus.done), 64'd1);
            chk({tag, ".dvld"},  64'(bus.out_valid), 64'd0);
            chk({tag, ".drdy"},  64'(bus.ready), 64'd0);
            chk({tag, ".dout"},  64'(bus.out), 64'd0);
            @(negedge clk);
            bus.start = 1'b0;
            check_idle({tag, ".post"});
            @(negedge clk);
            check_idle({tag, ".post2"});
        end
        $display("xfer %s: ud=%0b pat=%b rep=%0d bits_seen=%0d", tag, ud, pat, r, sent);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.use_default = 1'b0;
        bus.pat_in      = '0;
        bus.rep         = '0;
        bus.abort       = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("rst");
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_rel");

        send("def_r1", 1'b1, 4'b0000, 4'd1, 4, 64'b1011, -1, 1'b0);

        send("def_r3", 1'b1, 4'b0000, 4'd3, 12, 64'b101110111011, -1, 1'b0);
        chk("def_r3.matches", g_mask, 64'h888);

        send("pat_r2_poke", 1'b0, 4'b0110, 4'd2, 8, 64'b01100110, -1, 1'b1);

        // zero repeat count: start is dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.rep   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("rep0.c%0d", i));
        end
        bus.start = 1'b0;
        $display("xfer rep0: start with rep=0 ignored");

        // abort together with start in IDLE: start is dropped
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        bus.rep         = 4'd1;
        bus.use_default = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle("abt_idle");
        $display("xfer abt_idle: start with abort ignored");

        send("abort", 1'b1, 4'b0000, 4'd2, 8, 64'b10111011, 2, 1'b0);

        // asynchronous reset between edges in the middle of a transfer
        @(negedge clk);
        bus.start       = 1'b1;
        bus.use_default = 1'b1;
        bus.rep         = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("arst.b0", 64'(bus.out), 64'd1);
        @(negedge clk);
        chk("arst.vld1", 64'(bus.out_valid), 64'd1);
        chk("arst.b1", 64'(bus.out), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check_idle("arst.now");
        @(negedge clk);
        check_idle("arst.held");
        rst = 1'b0;
        $display("xfer arst: reset mid-shift");

        send("after_rst", 1'b1, 4'b0000, 4'd1, 4, 64'b1011, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_gen_serial.md
Name: seq_gen_serial

Overview:
Serial pattern transmitter, the transmit-side counterpart of the team's serial sequence detectors. On a start request it latches a WIDTH-bit pattern and a repeat count. It then shifts the pattern out MSB-first, one bit per clock, for the requested number of back-to-back copies. It sits upstream of a detector, or drives a serial line directly, and signals completion with a one-cycle done pulse.

Parameters:
WIDTH, 4, pattern length in bits (minimum 2)
DEFAULT_PAT, 4'b1011, pattern sent when use_default=1 (WIDTH bits)
CNT_W, 4, width of repeat-count input

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  asynchronous active-high reset
start  input  1  request; accepted only when ready=1
use_default  input  1  sampled with start: 1 selects DEFAULT_PAT, 0 selects pat_in
pat_in  input  WIDTH  pattern, sampled with start
rep  input  CNT_W  number of copies to send, sampled with start
abort  input  1  terminate transmission
ready  output  1  block idle, can accept start
out  output  1  serial data bit (registered)
out_valid  output  1  out carries a pattern bit this cycle (registered)
done  output  1  one-cycle pulse after last bit of a completed transfer

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (RST).
- Reset values: state=IDLE, ready=1, out=0, out_valid=0, done=0. Pattern, bit and copy registers are cleared to 0.
- All outputs are registered or decoded from state only; no combinational input-to-output path.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, out=0, out_valid=0.
  - start=1 with rep!=0: latch pattern (DEFAULT_PAT if use_default, else pat_in) and rep; bit index=WIDTH-1; copy count=rep; go to SHIFT.
  - start=1 with rep=0: ignored; stay IDLE; no done pulse.
  - abort in IDLE: no effect. When abort=1 and start=1 in the same IDLE cycle, start is ignored.
- SHIFT:
  - ready=0, out_valid=1, out=pattern[bit index].
  - Each cycle the bit index decrements. At index 0 it wraps to WIDTH-1 and copy count decrements.
  - When index=0 and copy count=1, the next state is DONE.
  - Copies are contiguous, with no idle bit between them.
- DONE: lasts exactly one cycle. done=1, out_valid=0, out=0, ready=0. Next state is IDLE.
- Timing, with start accepted at edge T and N=rep:
  - bits appear in cycles T+1 .. T+N*WIDTH;
  - done=1 in cycle T+N*WIDTH+1;
  - ready=1 again from cycle T+N*WIDTH+2.
- start while ready=0 is ignored; nothing is queued.
- abort=1 in SHIFT: next cycle goes to IDLE with out=0, out_valid=0, ready=1, and no done pulse. The bit currently presented is the last valid bit. abort in DONE: done still pulses, then IDLE.
- Inputs pat_in, use_default and rep are don't-care outside the start-accept cycle. Changing them mid-transfer has no effect.
- RST asserted mid-transfer: all outputs go to reset values immediately (asynchronous). out_valid drops and no done pulse is produced.
- Maximum transfer is (2^CNT_W - 1)*WIDTH bits. Copy counter width is CNT_W; bit index width is clog2(WIDTH).

Test Plan:
- Reset, then start, use_default=1, rep=1 -> out_valid high for 4 cycles with out=1,0,1,1; done=1 on the 5th cycle; ready=1 on the 6th.
- use_default=1, rep=3 -> 12 contiguous valid bits 101110111011. Serial 1011 matches (overlap allowed) complete at bit positions 4, 8 and 12; done at cycle 13.
- use_default=0, pat_in=4'b0110, rep=2 -> bits 01100110; done pulse once; pulsing start during SHIFT and DONE changes nothing.
- start with rep=0 -> remains IDLE; ready stays 1; out_valid and done never assert.
- rep=2 with abort asserted during the 3rd valid bit -> 3 valid bits (1,0,1), then out_valid=0 and ready=1 next cycle; done never asserts.
- RST asserted asynchronously mid-SHIFT (between edges) -> out, out_valid and done go to 0 and ready goes to 1 immediately. After release, a new start with rep=1 sends 1011 correctly.
